// File: rtl/bus_data_router.sv
// Registered N-source read-return router: grants one source per read strobe,
// inserts wait states, latches data until the strobe ends. Optional stall
// timeout is enabled by defining BUS_DATA_ROUTER_TIMEOUT_EN.
module bus_data_router #(
    parameter int SOURCES    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          read_n,
    input  logic [SOURCES-1:0]            source_claim,
    input  logic [SOURCES*DATA_WIDTH-1:0] source_data,
    input  logic [SOURCES-1:0]            source_ready,
    input  logic [SOURCES*WAIT_WIDTH-1:0] source_wait,
    input  logic                          ext_claim,
    input  logic [DATA_WIDTH-1:0]         ext_data,
    input  logic                          ext_ready,
    input  logic                          conflict_clear,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          bus_ready,
    output logic                          data_bus_direction,
    output logic [3:0]                    grant_index,
    output logic                          conflict,
    output logic                          timeout_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] GRANT_NONE = 4'd15;
    localparam logic [3:0] GRANT_EXT  = 4'(SOURCES);

    if (SOURCES < 1 || SOURCES > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("bus_data_router: parameter out of range");
    end

    logic [1:0]            state;
    logic                  read_q;
    logic                  prev_read;
    logic                  armed;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic [3:0]            pick;
    logic [WAIT_WIDTH-1:0] pick_wait;
    logic [3:0]            n_claims;
    logic                  start;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_data;

    // Reverse scan so the lowest-index claim wins; external only when no claim.
    always_comb begin
        pick      = GRANT_NONE;
        pick_wait = '0;
        n_claims  = '0;
        if (ext_claim) pick = GRANT_EXT;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (source_claim[i]) begin
                pick      = 4'(i);
                pick_wait = source_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
            end
            n_claims = n_claims + {3'b000, source_claim[i]};
        end
    end

    always_comb begin
        sel_ready = 1'b1;
        sel_data  = '0;
        if (grant_index == GRANT_EXT) begin
            sel_ready = ext_ready;
            sel_data  = ext_data;
        end
        for (int i = 0; i < SOURCES; i++) begin
            if (grant_index == 4'(i)) begin
                sel_ready = source_ready[i];
                sel_data  = source_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // armed blocks a spurious start when read_n is already low out of reset.
    assign start = (state == S_IDLE) && armed && prev_read && !read_q;

`ifdef BUS_DATA_ROUTER_TIMEOUT_EN
    logic [15:0] timeout_cnt;
`else
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            read_q             <= 1'b0;
            prev_read          <= 1'b1;
            armed              <= 1'b0;
            wait_cnt           <= '0;
            data_out           <= '0;
            bus_ready          <= 1'b0;
            data_bus_direction <= 1'b0;
            grant_index        <= GRANT_NONE;
            conflict           <= 1'b0;
`ifdef BUS_DATA_ROUTER_TIMEOUT_EN
            timeout_cnt        <= '0;
            timeout_error      <= 1'b0;
`endif
        end else begin
            read_q    <= read_n;
            prev_read <= read_q;
            armed     <= armed | read_q;
`ifdef BUS_DATA_ROUTER_TIMEOUT_EN
            timeout_error <= 1'b0;
`endif
            if (conflict_clear) conflict <= 1'b0;
            else if (start && n_claims > 4'd1) conflict <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        grant_index        <= pick;
                        data_bus_direction <= (pick == GRANT_EXT);
                        wait_cnt           <= pick_wait;
`ifdef BUS_DATA_ROUTER_TIMEOUT_EN
                        timeout_cnt        <= '0;
`endif
                        state              <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (read_q) begin
                        grant_index        <= GRANT_NONE;
                        data_bus_direction <= 1'b0;
                        state              <= S_IDLE;
                    end else if (wait_cnt == '0 && sel_ready) begin
                        data_out  <= sel_data;
                        bus_ready <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
`ifdef BUS_DATA_ROUTER_TIMEOUT_EN
                        if (timeout_cnt == 16'(TIMEOUT - 1)) begin
                            data_out      <= '1;
                            bus_ready     <= 1'b1;
                            timeout_error <= 1'b1;
                            state         <= S_HOLD;
                        end else begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
`endif
                    end
                end
                S_HOLD: begin
                    if (read_q) begin
                        data_out           <= '0;
                        bus_ready          <= 1'b0;
                        grant_index        <= GRANT_NONE;
                        data_bus_direction <= 1'b0;
                        state              <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
